nes_joypad_ctrl: RTL

//  Bridges the USB keyboard keycodes from the NIOS system (keycode_export: four 8-bit HID usages) to the

---
 rtl/nes_joypad_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/nes_joypad_ctrl.sv
// nes_joypad_ctrl
//   Maps USB HID keycodes (four usage slots) onto two NES joypads and serves
//   the $4016/$4017 strobe + serial-read protocol to the emulated CPU.
//   Button vector order (bit0..7): A, B, Select, Start, Up, Down, Left, Right.
//
// Ports
//   clk_clk        : system clock
//   reset_reset    : synchronous active-high reset
//   keycode_export : four HID usages {byte3,byte2,byte1,byte0}, 8'h00 = empty
//   cpu_ce         : one-cycle bus enable qualifying cpu_we / cpu_re
//   cpu_addr       : CPU address
//   cpu_din        : CPU write data (bit0 = strobe)
//   cpu_we, cpu_re : write / read request
//   joy_dout       : read data {7'b0100000, serial_bit}, registered
//   joy_oe         : one-cycle pulse, joy_dout valid
//   pad1_state     : live (registered) P1 button vector for debug LEDs
//
// Configuration macro
//   JOYPAD_SOCD_EN : when defined, L+R and U+D pairs cancel to 0 before the
//                    vector reaches the shift registers and pad1_state.

// One joypad shift register. The mode is decoded from the shared strobe and
// this port's read count rather than stored, so a strobe edge takes effect
// on the very next cycle with no extra state to keep coherent.
module nes_joypad_port #(
    parameter logic FILL_BIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    input  logic [7:0] vec,
    input  logic       rd,
    output logic       serial_bit
);
    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_EMPTY = 2'd2;

    logic [7:0] sh;
    logic [3:0] cnt;
    logic [1:0] state;

    always_comb begin
        if (strobe)            state = S_LOAD;
        else if (cnt == 4'd8)  state = S_EMPTY;
        else                   state = S_SHIFT;
    end

    always_comb begin
        case (state)
            S_LOAD:  serial_bit = vec[0];
            S_SHIFT: serial_bit = sh[0];
            default: serial_bit = FILL_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= 8'h00;
            cnt <= 4'd0;
        end else begin
            case (state)
                // Reload continuously; on strobe 1->0 sh keeps the last load.
                S_LOAD: begin
                    sh  <= vec;
                    cnt <= 4'd0;
                end
                S_SHIFT: begin
                    if (rd) begin
                        sh  <= {FILL_BIT, sh[7:1]};
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ; // EMPTY: count saturated at 8
            endcase
        end
    end
endmodule

module nes_joypad_ctrl #(
    parameter logic [15:0] P1_ADDR  = 16'h4016,
    parameter logic [15:0] P2_ADDR  = 16'h4017,
    parameter logic        FILL_BIT = 1'b1
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] keycode_export,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  joy_dout,
    output logic        joy_oe,
    output logic [7:0]  pad1_state
);
    localparam int NUM_PORTS = 2;

    // Usage code per button, [port][button], button index = vector bit.
    localparam logic [NUM_PORTS-1:0][7:0][7:0] KEY_MAP = '{
        '{8'h4F, 8'h50, 8'h51, 8'h52, 8'h2F, 8'h30, 8'h11, 8'h10},  // P2
        '{8'h07, 8'h04, 8'h16, 8'h1A, 8'h28, 8'h2B, 8'h0D, 8'h0E}   // P1
    };
    localparam logic [NUM_PORTS-1:0][15:0] PORT_ADDR = '{P2_ADDR, P1_ADDR};

    logic                          strobe;
    logic [NUM_PORTS-1:0][7:0]     vec_raw;
    logic [NUM_PORTS-1:0][7:0]     vec_clean;
    logic [NUM_PORTS-1:0][7:0]     vec_q;
    logic [NUM_PORTS-1:0]          rd;
    logic [NUM_PORTS-1:0]          serial;
    logic                          rd_ok;
    logic                          unused_din;

    // Only bit0 of the strobe write is meaningful.
    assign unused_din = ^cpu_din[7:1];

    // A read coinciding with a write is dropped; the write wins.
    assign rd_ok = cpu_ce & cpu_re & ~cpu_we;

    always_comb begin
        vec_raw = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int b = 0; b < 8; b++)
                for (int s = 0; s < 4; s++)
                    if (KEY_MAP[p][b] != 8'h00 &&
                        keycode_export[s*8 +: 8] == KEY_MAP[p][b])
                        vec_raw[p][b] = 1'b1;
    end

`ifdef JOYPAD_SOCD_EN
    // Opposing directions cancel: bits 7:6 = Right/Left, 5:4 = Down/Up.
    always_comb begin
        vec_clean = vec_raw;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (vec_raw[p][6] && vec_raw[p][7]) vec_clean[p][7:6] = 2'b00;
            if (vec_raw[p][4] && vec_raw[p][5]) vec_clean[p][5:4] = 2'b00;
        end
    end
`else
    assign vec_clean = vec_raw;
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vec_q  <= '0;
            strobe <= 1'b0;
        end else begin
            vec_q <= vec_clean;
            if (cpu_ce && cpu_we && cpu_addr == P1_ADDR)
                strobe <= cpu_din[0];
        end
    end

    assign pad1_state = vec_q[0];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign rd[p] = rd_ok && (cpu_addr == PORT_ADDR[p]);

        nes_joypad_port #(.FILL_BIT(FILL_BIT)) u_port (
            .clk        (clk_clk),
            .reset      (reset_reset),
            .strobe     (strobe),
            .vec        (vec_q[p]),
            .rd         (rd[p]),
            .serial_bit (serial[p])
        );
    end

    // joy_dout holds its last value between reads; joy_oe marks validity.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            joy_dout <= 8'h00;
            joy_oe   <= 1'b0;
        end else begin
            joy_oe <= |rd;
            if (rd[0])      joy_dout <= {7'b0100000, serial[0]};
            else if (rd[1]) joy_dout <= {7'b0100000, serial[1]};
        end
    end
endmodule
